// File: rtl/button_conditioner_pkg.sv
// ============================================================================
// Module      : game_2048_pkg
// Description : Shared types and helpers for the 2048 button front end.
//               Button index map (0=UP, 1=DOWN, 2=LEFT, 3=RIGHT), the
//               4-bit button vector type, conditioner FSM state encoding
//               and a lowest-index one-hot arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_2048_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  typedef logic [3:0] btn_vec_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } cond_state_t;

  // One-hot of the lowest set bit: UP beats DOWN beats LEFT beats RIGHT.
  // The loop runs from the highest index down so the lowest set bit is
  // the last (winning) assignment.
  function automatic btn_vec_t lowest_onehot(input btn_vec_t v);
    btn_vec_t r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = btn_vec_t'(4'b0001 << i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_if.sv
// ============================================================================
// Module      : button_conditioner_if
// Description : Bundle between the board buttons, the conditioner and the
//               2048 next-state logic.
//   raw_btn  [3:0] asynchronous board buttons
//   buttons  [3:0] one-hot single-cycle move pulse
//   btn_held       a press is accepted and not yet fully released
//   master : conditioner side (reads raw_btn, drives buttons/btn_held)
//   slave  : board/consumer side (drives raw_btn, reads buttons/btn_held)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_conditioner_if;

  game_2048_pkg::btn_vec_t raw_btn;
  game_2048_pkg::btn_vec_t buttons;
  logic                    btn_held;

  modport master (
    input  raw_btn,
    output buttons,
    output btn_held
  );

  modport slave (
    output raw_btn,
    input  buttons,
    input  btn_held
  );

endinterface

`default_nettype wire

// File: rtl/button_conditioner_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Single-bit two-flop synchroniser followed by a counter-based
//               debouncer. The debounced level toggles only after the
//               synchronised input has differed from it for DEBOUNCE_CYCLES
//               consecutive cycles; any return to the current level restarts
//               the count.
//   clk        system clock
//   rst        asynchronous active-high reset
//   i_raw      raw asynchronous button pin
//   o_db       debounced, active-high pressed level
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_db
);

  localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level of a released button, used as the synchroniser reset value.
  localparam logic              C_REL     = ACTIVE_LOW;

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lvl;

  // Polarity correction happens after the second flop so the synchroniser
  // sees the raw pin directly.
  assign w_lvl = r_s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= C_REL;
      r_s2 <= C_REL;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (w_lvl == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == C_CNT_MAX) begin
      r_db  <= ~r_db;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_db = r_db;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : Turns four raw board buttons into one-hot, single-cycle move
//               requests for the 2048 next-state logic: per-bit synchronise
//               and debounce, rising-edge detect, lowest-index arbitration,
//               then lock-out until every button is released.
//   clk              system clock
//   rst_game         asynchronous active-high reset
//   bus.raw_btn      raw board buttons (0=UP,1=DOWN,2=LEFT,3=RIGHT)
//   bus.buttons      one-hot move pulse, one cycle wide
//   bus.btn_held     high while a press is locked out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import game_2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_game,
  button_conditioner_if.master bus
);

  localparam logic [0:0] C_S_IDLE = S_IDLE;
  localparam logic [0:0] C_S_HELD = S_HELD;

  btn_vec_t   w_db;
  btn_vec_t   w_rise;
  btn_vec_t   r_db_q;
  btn_vec_t   r_buttons;
  logic [0:0] r_state;
  logic       r_held;

  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_db (
      .clk   (clk),
      .rst   (rst_game),
      .i_raw (bus.raw_btn[i]),
      .o_db  (w_db[i])
    );
  end

  always_ff @(posedge clk or posedge rst_game) begin
    if (rst_game) r_db_q <= '0;
    else          r_db_q <= w_db;
  end

  assign w_rise = w_db & ~r_db_q;

  // Rises seen while held are dropped rather than queued, so a press can
  // produce at most one move.
  always_ff @(posedge clk or posedge rst_game) begin
    if (rst_game) begin
      r_state   <= C_S_IDLE;
      r_held    <= 1'b0;
      r_buttons <= '0;
    end else begin
      r_buttons <= '0;
      case (r_state)
        C_S_IDLE: begin
          if (w_rise != '0) begin
            r_buttons <= lowest_onehot(w_rise);
            r_state   <= C_S_HELD;
            r_held    <= 1'b1;
          end
        end
        C_S_HELD: begin
          if (w_db == '0) begin
            r_state <= C_S_IDLE;
            r_held  <= 1'b0;
          end
        end
        default: begin
          r_state <= C_S_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buttons  = r_buttons;
  assign bus.btn_held = r_held;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               DEBOUNCE_CYCLES=4. A clean press sampled at edge k shows its
//               pulse at the negedge sample after edge k+6 (index 6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;
  import game_2048_pkg::*;

  logic clk;
  logic rst_game;
  int   errors;
  int   checks;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk      (clk),
    .rst_game (rst_game),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Release all buttons and expect the lock-out to end after 7 edges.
  task automatic release_all(input string name);
    bus.raw_btn = 4'b0000;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      checks++;
      if (bus.buttons !== 4'b0000) begin
        errors++;
        $display("FAIL %s_release buttons cyc %0d: got %b want 0000", name, j, bus.buttons);
      end
      checks++;
      if (bus.btn_held !== (j < 6)) begin
        errors++;
        $display("FAIL %s_release held cyc %0d: got %b want %b", name, j, bus.btn_held, (j < 6));
      end
    end
  endtask

  // Drive a press and expect one pulse of 'exp' at sample index 6.
  task automatic press_expect(input string name, input btn_vec_t raw, input btn_vec_t exp, input int n);
    btn_vec_t eb;
    bus.raw_btn = raw;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eb = (i == 6) ? exp : 4'b0000;
      checks++;
      if (bus.buttons !== eb) begin
        errors++;
        $display("FAIL %s buttons cyc %0d: got %b want %b", name, i, bus.buttons, eb);
      end
      checks++;
      if (bus.btn_held !== (i >= 6)) begin
        errors++;
        $display("FAIL %s held cyc %0d: got %b want %b", name, i, bus.btn_held, (i >= 6));
      end
    end
  endtask

  // Hold a pattern while locked out: no pulse, held stays high.
  task automatic hold_quiet(input string name, input btn_vec_t raw, input int n);
    bus.raw_btn = raw;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (bus.buttons !== 4'b0000 || bus.btn_held !== 1'b1) begin
        errors++;
        $display("FAIL %s cyc %0d: got buttons=%b held=%b want buttons=0000 held=1",
                 name, i, bus.buttons, bus.btn_held);
      end
    end
  endtask

  task automatic test_reset();
    rst_game    = 1'b1;
    bus.raw_btn = 4'b0000;
    #20;
    checks++;
    if (bus.buttons !== 4'b0000 || bus.btn_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got buttons=%b held=%b want 0000/0", bus.buttons, bus.btn_held);
    end
    rst_game = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.buttons !== 4'b0000 || bus.btn_held !== 1'b0) begin
        errors++;
        $display("FAIL idle cyc %0d: got buttons=%b held=%b want 0000/0", i, bus.buttons, bus.btn_held);
      end
    end
  endtask

  task automatic test_single_press();
    press_expect("single_press", 4'b0001, 4'b0001, 20);
    release_all("single_press");
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 30; i++) begin
      bus.raw_btn = (i < 20 && ((i / 2) % 2 == 0)) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      checks++;
      if (bus.buttons !== 4'b0000 || bus.btn_held !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc %0d: got buttons=%b held=%b want 0000/0", i, bus.buttons, bus.btn_held);
      end
    end
  endtask

  task automatic test_simultaneous();
    press_expect("simultaneous", 4'b1010, 4'b0010, 20);
    hold_quiet("simul_release_one", 4'b1000, 15);
    release_all("simultaneous");
  endtask

  task automatic test_press_while_held();
    press_expect("while_held_first", 4'b0100, 4'b0100, 20);
    hold_quiet("while_held_second", 4'b0101, 15);
    hold_quiet("while_held_partial", 4'b0001, 15);
    release_all("while_held");
    press_expect("while_held_repress", 4'b0001, 4'b0001, 14);
    release_all("while_held_repress");
  endtask

  task automatic test_reset_mid_debounce();
    bus.raw_btn = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.buttons !== 4'b0000) begin
        errors++;
        $display("FAIL mid_debounce pre cyc %0d: got %b want 0000", i, bus.buttons);
      end
    end
    rst_game = 1'b1;
    #1;
    checks++;
    if (bus.buttons !== 4'b0000 || bus.btn_held !== 1'b0) begin
      errors++;
      $display("FAIL mid_debounce in_reset: got buttons=%b held=%b want 0000/0", bus.buttons, bus.btn_held);
    end
    @(negedge clk);
    rst_game = 1'b0;
    press_expect("mid_debounce_after", 4'b1000, 4'b1000, 14);
    release_all("mid_debounce");
  endtask

  task automatic test_reset_mid_pulse();
    bus.raw_btn = 4'b0001;
    for (int i = 0; i < 7; i++) @(negedge clk);
    checks++;
    if (bus.buttons !== 4'b0001) begin
      errors++;
      $display("FAIL mid_pulse pulse: got %b want 0001", bus.buttons);
    end
    rst_game = 1'b1;
    #1;
    checks++;
    if (bus.buttons !== 4'b0000 || bus.btn_held !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse async_clear: got buttons=%b held=%b want 0000/0", bus.buttons, bus.btn_held);
    end
    @(negedge clk);
    rst_game = 1'b0;
    press_expect("mid_pulse_after", 4'b0001, 4'b0001, 14);
    release_all("mid_pulse");
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_game    = 1'b1;
    bus.raw_btn = 4'b0000;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_press_while_held();
    test_reset_mid_debounce();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Producer side of the `buttons` bus consumed by the 2048 next-state logic.
- Converts four raw board push-buttons into clean, one-hot, single-cycle move requests: synchronise, debounce, edge-detect, arbitrate, then lock out until release.
- Guarantees exactly one move per physical press.
- Sits between the board pins and the `current_state`/`next_state` FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz). Benches use 4.
- ACTIVE_LOW, 0: 1 = raw pins read 0 when pressed. Inverted after the synchroniser.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): localparam, debounce counter width.

Ports:
- clk  in  1  system clock
- rst_game  in  1  asynchronous, active-high reset
- raw_btn  in  4  asynchronous board buttons; index map from package: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT
- buttons  out  4  one-hot move pulse, high for exactly one clk cycle, else 4'b0000
- btn_held  out  1  high while in S_HELD (a press has been accepted and not yet fully released)

Behaviour:
- Reset (async assert, sync-style release on the next clk edge):
  - sync flops = released level
  - debounced levels = 0, counters = 0
  - FSM = S_IDLE
  - buttons = 0, btn_held = 0
- Synchroniser: two flops per bit. ACTIVE_LOW inversion is applied after the second flop.
- Debounce, per bit:
  - If the synced level equals db[i], cnt[i] clears to 0.
  - Otherwise cnt[i] increments.
  - When cnt[i] reaches DEBOUNCE_CYCLES-1 while still differing, db[i] toggles and cnt[i] clears.
  - Any bounce (synced level returns to db[i]) restarts the count.
- Edge detect: rise = db & ~db_q, where db_q is db delayed one cycle.
- FSM, states S_IDLE and S_HELD:
  - S_IDLE, rise != 0:
    - buttons <= one-hot of the lowest-index set bit of rise (UP beats DOWN beats LEFT beats RIGHT)
    - next state S_HELD
  - S_IDLE, otherwise: buttons <= 0.
  - S_HELD: buttons <= 0. Transitions to S_IDLE when db == 4'b0000.
    - New rises in S_HELD are ignored, not queued.
  - btn_held = (state == S_HELD), registered with the state.
- Latency: a clean press first sampled high at edge k produces buttons high in the cycle following edge k+DEBOUNCE_CYCLES+2, i.e. visible after DEBOUNCE_CYCLES+3 edges.
- Pulse width: buttons is never high for two consecutive cycles.
- Boundary cases:
  - Simultaneous debounced presses: only the lowest index is reported.
  - A second button pressed while the first is held produces no pulse.
  - Releasing one of two held buttons produces no pulse.
  - All four released: the FSM returns to S_IDLE in the cycle after db reaches 0. An immediate re-press then requires a full debounce.
  - Glitch shorter than DEBOUNCE_CYCLES: no pulse.
  - Reset asserted mid-debounce or mid-pulse: outputs clear immediately (asynchronously). A button still held when reset deasserts is re-debounced and produces one pulse.

Decomposition:
- game_2048_pkg:
  - button index constants BTN_UP/DOWN/LEFT/RIGHT
  - typedef btn_vec_t (logic [3:0])
  - enum cond_state_t {S_IDLE, S_HELD}
- Sub-module button_debouncer (single bit: synchroniser + counter + db level, parameter DEBOUNCE_CYCLES), instantiated 4x via generate.
- Top holds edge detect, arbitration and FSM.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, 10 ns clk):
1. rst_game high 20 ns then low; raw_btn=0 for 20 cycles -> buttons=0000, btn_held=0 throughout.
2. raw_btn=0001 held 20 cycles -> exactly one cycle of buttons=0001, 7 edges after first sampling; btn_held=1 from that cycle until 7 cycles after release, then 0.
3. raw_btn[2] toggles 1/0 every 2 cycles for 20 cycles, then 0 -> buttons stays 0000.
4. raw_btn=1010 applied in the same cycle -> single pulse buttons=0010; no pulse for bit 3 while either is held.
5. raw_btn=0100 accepted; then raw_btn=0101 while held; then release bit 2 only; then release all -> only the initial 0100 pulse. Re-pressing 0001 afterwards yields 0001.
6. raw_btn=1000 held; rst_game pulsed at cycle 5 of debounce for 1 cycle -> buttons=0000 during reset, then exactly one 1000 pulse 7 edges after reset release.
